// File: rtl/seq_addsub_unit_if.sv
// Handshake and data bundle for the sequential add/subtract unit.
// master: requester (start/abort/op/a/b/k); slave: the unit (busy/done/result/flag/err).
interface seq_addsub_unit_if #(
    parameter int WIDTH = 16,
    parameter int KW    = 4
);
    logic             start;
    logic             abort;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [KW-1:0]    k;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             flag;
    logic             err;

    modport master (
        output start, abort, op, a, b, k,
        input  busy, done, result, flag, err
    );

    modport slave (
        input  start, abort, op, a, b, k,
        output busy, done, result, flag, err
    );
endinterface

// File: rtl/seq_addsub_unit.sv
// Sequential add / subtract / repeated-subtract unit (IDLE -> CALC -> DONE).
// Ports: clk, rst_n (async active-low), bus (slave modport of seq_addsub_unit_if).
module seq_addsub_unit #(
    parameter int WIDTH = 16,
    parameter int KW    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    seq_addsub_unit_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_acc;
    logic [KW-1:0]    r_cnt;
    logic             r_sbrw;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_result;
    logic             r_flag;
    logic             r_err;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_dif;
    logic             w_brw;

    assign w_sum = {1'b0, r_acc} + {1'b0, r_a};
    assign w_dif = r_acc - r_a;
    assign w_brw = (r_a > r_acc);

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;
    assign bus.flag   = r_flag;
    assign bus.err    = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_op     <= 2'b00;
            r_a      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_sbrw   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_flag   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    // abort has no meaning here; start alone decides
                    if (bus.start) begin
                        r_op   <= bus.op;
                        r_a    <= bus.a;
                        r_acc  <= bus.b;
                        r_sbrw <= 1'b0;
                        r_cnt  <= (bus.op == 2'b10) ? bus.k : KW'(1);
                        r_busy <= 1'b1;
                        r_state <= S_CALC;
                    end
                end

                S_CALC: begin
                    if (bus.abort) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        unique case (r_op)
                            2'b00: begin
                                r_result <= w_sum[WIDTH-1:0];
                                r_flag   <= w_sum[WIDTH];
                                r_err    <= 1'b0;
                                r_busy   <= 1'b0;
                                r_done   <= 1'b1;
                                r_state  <= S_DONE;
                            end
                            2'b01: begin
                                r_result <= w_dif;
                                r_flag   <= w_brw;
                                r_err    <= 1'b0;
                                r_busy   <= 1'b0;
                                r_done   <= 1'b1;
                                r_state  <= S_DONE;
                            end
                            2'b10: begin
                                if (r_cnt == '0) begin
                                    // k = 0: pass B through untouched
                                    r_result <= r_acc;
                                    r_flag   <= 1'b0;
                                    r_err    <= 1'b0;
                                    r_busy   <= 1'b0;
                                    r_done   <= 1'b1;
                                    r_state  <= S_DONE;
                                end else if (r_cnt == KW'(1)) begin
                                    // last step folds its own borrow in
                                    r_result <= w_dif;
                                    r_flag   <= r_sbrw | w_brw;
                                    r_err    <= 1'b0;
                                    r_busy   <= 1'b0;
                                    r_done   <= 1'b1;
                                    r_state  <= S_DONE;
                                end else begin
                                    r_acc  <= w_dif;
                                    r_sbrw <= r_sbrw | w_brw;
                                    r_cnt  <= r_cnt - KW'(1);
                                end
                            end
                            default: begin
                                r_result <= '0;
                                r_flag   <= 1'b0;
                                r_err    <= 1'b1;
                                r_busy   <= 1'b0;
                                r_done   <= 1'b1;
                                r_state  <= S_DONE;
                            end
                        endcase
                    end
                end

                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_addsub_unit.sv
// Directed bench for seq_addsub_unit: vector table plus abort/reset/back-to-back sequences.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
module tb_seq_addsub_unit;
    localparam int WIDTH = 16;
    localparam int KW    = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    seq_addsub_unit_if #(.WIDTH(WIDTH), .KW(KW)) bus ();

    seq_addsub_unit #(.WIDTH(WIDTH), .KW(KW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [KW-1:0]    k;
        logic [WIDTH-1:0] res;
        logic             flag;
        logic             err;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Entered at posedge+1 of an IDLE cycle; leaves at posedge+1 of
    // the IDLE cycle following DONE.
    task automatic run(input vec_t v);
        int n;
        n = (v.op == 2'b10) ? ((v.k == 0) ? 1 : int'(v.k)) : 1;
        bus.start = 1'b1;
        bus.op    = v.op;
        bus.a     = v.a;
        bus.b     = v.b;
        bus.k     = v.k;
        @(posedge clk); #1;
        bus.start = 1'b0;
        // operands scrambled while busy must not matter
        bus.a = ~v.a;
        bus.b = ~v.b;
        bus.k = ~v.k;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            chk("busy_in_calc", {30'd0, bus.busy, bus.done}, 32'd2);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("done_pulse", {30'd0, bus.busy, bus.done}, 32'd1);
        chk("result", 32'(bus.result), 32'(v.res));
        chk("flag", 32'(bus.flag), 32'(v.flag));
        chk("err", 32'(bus.err), 32'(v.err));
        @(posedge clk); #1;
        @(negedge clk);
        chk("done_drop", 32'(bus.done), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        vecs[0]  = '{2'b00, 16'h0001, 16'hFFFF, 4'd0, 16'h0000, 1'b1, 1'b0};
        vecs[1]  = '{2'b01, 16'h0007, 16'h0005, 4'd0, 16'hFFFE, 1'b1, 1'b0};
        vecs[2]  = '{2'b01, 16'h0003, 16'h000A, 4'd0, 16'h0007, 1'b0, 1'b0};
        vecs[3]  = '{2'b10, 16'd7,    16'd100,  4'd3, 16'h004F, 1'b0, 1'b0};
        vecs[4]  = '{2'b10, 16'd4,    16'd10,   4'd3, 16'hFFFE, 1'b1, 1'b0};
        vecs[5]  = '{2'b10, 16'd9,    16'h1234, 4'd0, 16'h1234, 1'b0, 1'b0};
        vecs[6]  = '{2'b11, 16'd5,    16'd7,    4'd2, 16'h0000, 1'b0, 1'b1};
        vecs[7]  = '{2'b00, 16'h8000, 16'h8000, 4'd0, 16'h0000, 1'b1, 1'b0};
        vecs[8]  = '{2'b10, 16'd1,    16'd20,   4'd15, 16'd5,   1'b0, 1'b0};
        vecs[9]  = '{2'b10, 16'h1000, 16'h2000, 4'd3, 16'hF000, 1'b1, 1'b0};
        vecs[10] = '{2'b00, 16'h1234, 16'h0101, 4'd0, 16'h1335, 1'b0, 1'b0};

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        bus.k     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", {bus.busy, bus.done, bus.flag, bus.err,
                           12'd0, bus.result}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) run(vecs[i]);

        // abort in cycle 2 of an op-10 k=5 run; restart in cycle 3
        bus.start = 1'b1;
        bus.op = 2'b10; bus.a = 16'd1; bus.b = 16'd9; bus.k = 4'd5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        bus.abort = 1'b1;
        @(negedge clk);
        chk("abort_busy_c2", 32'(bus.busy), 32'd1);
        @(posedge clk); #1;
        bus.abort = 1'b0;
        bus.start = 1'b1;
        bus.op = 2'b00; bus.a = 16'd1; bus.b = 16'd2; bus.k = 4'd0;
        @(negedge clk);
        chk("abort_idle_c3", {30'd0, bus.busy, bus.done}, 32'd0);
        chk("abort_keep_res", 32'(bus.result), 32'h1335);
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        chk("restart_busy", 32'(bus.busy), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("restart_done", {15'd0, bus.done, bus.result}, {15'd0, 1'b1, 16'd3});
        @(posedge clk); #1;

        // start and abort together in IDLE: start wins
        bus.start = 1'b1;
        bus.abort = 1'b1;
        bus.op = 2'b01; bus.a = 16'd1; bus.b = 16'd4;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        @(negedge clk);
        chk("start_abort_idle", 32'(bus.busy), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("start_abort_res", {15'd0, bus.done, bus.result}, {15'd0, 1'b1, 16'd3});
        @(posedge clk); #1;

        // asynchronous reset in the middle of op 10, k = 9
        bus.start = 1'b1;
        bus.op = 2'b10; bus.a = 16'd1; bus.b = 16'd50; bus.k = 4'd9;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", {bus.busy, bus.done, bus.flag, bus.err,
                            12'd0, bus.result}, 32'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run('{2'b00, 16'd1, 16'd1, 4'd0, 16'd2, 1'b0, 1'b0});

        // start held high: accept / CALC / DONE repeating every 3 cycles
        bus.start = 1'b1;
        bus.op = 2'b00; bus.a = 16'd1; bus.b = 16'd5;
        for (int c = 0; c < 9; c++) begin
            if (c % 3 == 0) begin
                bus.a = 16'd1;
                bus.b = 16'd5;
            end else begin
                bus.a = 16'hAAAA;
                bus.b = 16'h0000;
            end
            @(negedge clk);
            chk("held_busy", 32'(bus.busy), 32'((c % 3) == 1));
            chk("held_done", 32'(bus.done), 32'((c % 3) == 2));
            if (c % 3 == 2) chk("held_result", 32'(bus.result), 32'd6);
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        @(negedge clk);
        chk("held_stop", {30'd0, bus.busy, bus.done}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/seq_addsub_unit.md
SEQ_ADDSUB_UNIT -- requirements
Module: seq_addsub_unit

Interface
REQ-001 Parameter: WIDTH, 16, operand and result width in bits (≥2).
REQ-002 Parameter: KW, 4, width of the repeat count k.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  request a new operation.
REQ-006 abort  in  1  synchronous cancel of the operation in progress.
REQ-007 op  in  2  operation select: 00 = A+B, 01 = B−A, 10 = B−k·A, 11 = reserved.
REQ-008 a  in  WIDTH  operand A, unsigned.
REQ-009 b  in  WIDTH  operand B, unsigned.
REQ-010 k  in  KW  repeat count for op 10, unsigned.
REQ-011 busy  out  1  high while in CALC.
REQ-012 done  out  1  one-cycle completion pulse.
REQ-013 result  out  WIDTH  registered result.
REQ-014 flag  out  1  carry (op 00) or borrow (ops 01/10).
REQ-015 err  out  1  high with done when op was reserved.

Function
REQ-016 FSM SHALL have states IDLE, CALC and DONE, with IDLE entered at reset.
REQ-017 start SHALL be accepted only in IDLE; start in CALC or DONE is ignored (no queueing).
REQ-018 On the accepting edge: capture a, b, k, op; load accumulator = b; clear sticky borrow; load step counter = k (op 10) or 1 (others); go to CALC.
REQ-019 CALC, op 00: accumulator = (acc + A) mod 2^WIDTH, flag = carry-out; 1 step.
REQ-020 CALC, op 01: accumulator = (acc − A) mod 2^WIDTH, flag = 1 iff A > acc unsigned; 1 step.
REQ-021 CALC, op 10: one subtraction of A per cycle, counter decrements; sticky borrow set if any step has A > acc; flag = sticky borrow at completion.
REQ-022 op 10 with k = 0: one CALC cycle, no subtraction, result = B, flag = 0.
REQ-023 op 11: one CALC cycle, result = 0, flag = 0, err = 1 in DONE.
REQ-024 Latency: start accepted in cycle 0 -> busy in cycles 1..n -> done = 1 in cycle n+1, where n = max(k,1) for op 10 and n = 1 otherwise.
REQ-025 DONE SHALL last exactly one cycle, then return to IDLE; a new start is accepted from the following IDLE cycle.
REQ-026 result, flag and err SHALL update only on the CALC->DONE transition and hold until the next completion.
REQ-027 abort high in CALC: go to IDLE on the next edge; no done; result/flag/err unchanged.
REQ-028 abort in IDLE or DONE SHALL be ignored; start and abort both high in IDLE: abort ignored, start accepted.
REQ-029 Operand changes after acceptance SHALL not affect the operation in progress.
REQ-030 Arithmetic is wrap-around modulo 2^WIDTH; no saturation.

Reset
REQ-031 rst_n low SHALL immediately force: state IDLE, busy 0, done 0, result 0, flag 0, err 0, accumulator and counter 0, regardless of the operation in progress.
REQ-032 After rst_n rises, the first start SHALL be accepted on the first clock edge with start high.

Verification (WIDTH=16, KW=4)
REQ-033 op 00, a=0x0001, b=0xFFFF, start in cycle 0 -> done in cycle 2, result 0x0000, flag 1, err 0.
REQ-034 op 01, a=0x0007, b=0x0005 -> done in cycle 2, result 0xFFFE, flag 1; op 01, a=3, b=10 -> result 0x0007, flag 0.
REQ-035 op 10, a=7, b=100, k=3 -> busy in cycles 1-3, done in cycle 4, result 79 (0x004F), flag 0; repeat with a=4, b=10, k=3 -> result 0xFFFE, flag 1; k=0, b=0x1234 -> done in cycle 2, result 0x1234, flag 0.
REQ-036 op 10, k=5, abort high in cycle 2 -> IDLE in cycle 3, no done pulse, result equals the previous completion; a start in cycle 3 is accepted.
REQ-037 rst_n low mid-CALC (op 10, k=9) -> all outputs 0 with no clock edge required; restart with op 00, a=1, b=1 -> done 2 cycles after start, result 2.
REQ-038 Start held high continuously with op 00 -> done every third cycle (accept, CALC, DONE); operand changes during busy do not alter result; op 11 -> err 1 with done, result 0.
